// File: rtl/cpu_pkg.sv
// Shared types and sizes for the integer datapath: register width, index width,
// register count and the retire counter width.
package cpu_pkg;

   localparam int XLEN = 64;
   localparam int NREG = 32;
   localparam int AW   = 5;
   localparam int CNTW = 32;

   typedef logic [AW-1:0]   reg_idx_t;
   typedef logic [XLEN-1:0] xword_t;

   localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_regfile_if.sv
// Bus bundle between the MEM/WB pipeline register / ID stage and the
// writeback register file. The master drives the pipeline-side inputs and
// the read indices; the slave (register file) returns read data, the selected
// writeback value and the commit/debug outputs.
interface wb_regfile_if
   import cpu_pkg::*;
#(
   parameter int CNTW = cpu_pkg::CNTW
);

   xword_t            readdata;
   xword_t            result_alu_out;
   reg_idx_t          rd;
   logic              Memtoreg;
   logic              Regwrite;
   reg_idx_t          rs1;
   reg_idx_t          rs2;
   xword_t            rdata1;
   xword_t            rdata2;
   xword_t            wb_data;
   logic              wb_commit;
   reg_idx_t          wb_rd;
   logic [CNTW-1:0]   retire_count;

   modport master (
      output readdata, result_alu_out, rd, Memtoreg, Regwrite, rs1, rs2,
      input  rdata1, rdata2, wb_data, wb_commit, wb_rd, retire_count
   );

   modport slave (
      input  readdata, result_alu_out, rd, Memtoreg, Regwrite, rs1, rs2,
      output rdata1, rdata2, wb_data, wb_commit, wb_rd, retire_count
   );

endinterface

// File: rtl/wb_select.sv
// Writeback value selection and write-enable qualification. A write only
// counts when it is requested, targets a real register (not x0) and reset
// is not holding the block.
module wb_select
   import cpu_pkg::*;
(
   input  xword_t   readdata,
   input  xword_t   result_alu_out,
   input  logic     Memtoreg,
   input  logic     Regwrite,
   input  reg_idx_t rd,
   input  logic     reset,
   output xword_t   wb_data,
   output logic     we_eff
);

   assign wb_data = Memtoreg ? readdata : result_alu_out;
   assign we_eff  = Regwrite && (rd != REG_ZERO) && !reset;

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage register file: commits the selected writeback value into
// a 32 x 64-bit register file, serves two combinational read ports with a
// same-cycle write-to-read bypass, and tracks commits for debug visibility.
module wb_regfile
   import cpu_pkg::*;
#(
   parameter int CNTW = cpu_pkg::CNTW
)(
   input logic        clk,
   input logic        reset,
   wb_regfile_if.slave bus
);

   xword_t          regs [NREG];
   xword_t          wb_data;
   logic            we_eff;
   xword_t          rdata1;
   xword_t          rdata2;
   logic            commit_q;
   reg_idx_t        wb_rd_q;
   logic [CNTW-1:0] count_q;

   wb_select u_select (
      .readdata       (bus.readdata),
      .result_alu_out (bus.result_alu_out),
      .Memtoreg       (bus.Memtoreg),
      .Regwrite       (bus.Regwrite),
      .rd             (bus.rd),
      .reset          (reset),
      .wb_data        (wb_data),
      .we_eff         (we_eff)
   );

   // Register array: cleared by reset, written on the edge of an effective write.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if (we_eff) begin
         regs[bus.rd] <= wb_data;
      end
   end

   // Read port 1: x0 reads zero, a matching in-flight write is forwarded.
   always_comb begin
      rdata1 = '0;
      if (!reset && bus.rs1 != REG_ZERO) begin
         if (we_eff && bus.rd == bus.rs1) begin
            rdata1 = wb_data;
         end else begin
            rdata1 = regs[bus.rs1];
         end
      end
   end

   // Read port 2: same rules as port 1, independent index.
   always_comb begin
      rdata2 = '0;
      if (!reset && bus.rs2 != REG_ZERO) begin
         if (we_eff && bus.rd == bus.rs2) begin
            rdata2 = wb_data;
         end else begin
            rdata2 = regs[bus.rs2];
         end
      end
   end

   // Commit tracking: one-cycle pulse, last written index, wrapping retire count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         commit_q <= 1'b0;
         wb_rd_q  <= REG_ZERO;
         count_q  <= '0;
      end else begin
         commit_q <= we_eff;
         count_q  <= count_q + CNTW'(we_eff);
         if (we_eff) begin
            wb_rd_q <= bus.rd;
         end
      end
   end

   assign bus.wb_data      = wb_data;
   assign bus.rdata1       = rdata1;
   assign bus.rdata2       = rdata2;
   assign bus.wb_commit    = commit_q;
   assign bus.wb_rd        = wb_rd_q;
   assign bus.retire_count = count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Testbench for wb_regfile: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against a behavioural model.
// A second instance with a 4-bit retire counter exercises counter wrap-around.
module tb_wb_regfile;
   import cpu_pkg::*;

   localparam int SMALLW = 4;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   logic checkEn = 1'b0;
   int   checks = 0;
   int   errors = 0;

   wb_regfile_if                  bus   ();
   wb_regfile_if #(.CNTW(SMALLW)) bus_s ();

   wb_regfile dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   wb_regfile #(.CNTW(SMALLW)) dut_s (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_s)
   );

   assign bus_s.readdata       = bus.readdata;
   assign bus_s.result_alu_out = bus.result_alu_out;
   assign bus_s.rd             = bus.rd;
   assign bus_s.Memtoreg       = bus.Memtoreg;
   assign bus_s.Regwrite       = bus.Regwrite;
   assign bus_s.rs1            = bus.rs1;
   assign bus_s.rs2            = bus.rs2;

   always #5 clk = ~clk;

   // Behavioural model state: architectural registers and commit bookkeeping.
   xword_t          mreg [NREG];
   logic [CNTW-1:0] mcount  = '0;
   logic            mcommit = 1'b0;
   reg_idx_t        mwbrd   = '0;

   function automatic xword_t selData();
      return bus.Memtoreg ? bus.readdata : bus.result_alu_out;
   endfunction

   function automatic logic writeHappens();
      return bus.Regwrite && (bus.rd != 0) && !reset;
   endfunction

   function automatic xword_t expRead(reg_idx_t idx);
      if (reset || idx == 0) return '0;
      if (writeHappens() && bus.rd == idx) return selData();
      return mreg[idx];
   endfunction

   // Model update on each clock edge, cleared asynchronously by reset.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         foreach (mreg[i]) mreg[i] <= '0;
         mcount  <= '0;
         mcommit <= 1'b0;
         mwbrd   <= '0;
      end else begin
         mcommit <= writeHappens();
         if (writeHappens()) begin
            mreg[bus.rd] <= selData();
            mcount       <= mcount + 1'b1;
            mwbrd        <= bus.rd;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare process: every output against the model, mid-cycle away from edges.
   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("wb_data",        bus.wb_data,             selData());
         checkOutput("rdata1",         bus.rdata1,              expRead(bus.rs1));
         checkOutput("rdata2",         bus.rdata2,              expRead(bus.rs2));
         checkOutput("wb_commit",      64'(bus.wb_commit),      64'(mcommit));
         checkOutput("wb_rd",          64'(bus.wb_rd),          64'(mwbrd));
         checkOutput("retire_count",   64'(bus.retire_count),   64'(mcount));
         checkOutput("retire_small",   64'(bus_s.retire_count), 64'(mcount[SMALLW-1:0]));
      end
   end

   task automatic applyStimulus(input logic rw, input logic m2r, input reg_idx_t rdIdx,
                                input xword_t rdData, input xword_t aluData,
                                input reg_idx_t r1, input reg_idx_t r2);
      @(posedge clk);
      #1;
      bus.Regwrite       = rw;
      bus.Memtoreg       = m2r;
      bus.rd             = rdIdx;
      bus.readdata       = rdData;
      bus.result_alu_out = aluData;
      bus.rs1            = r1;
      bus.rs2            = r2;
   endtask

   initial begin
      foreach (mreg[i]) mreg[i] = '0;
      bus.Regwrite       = 1'b0;
      bus.Memtoreg       = 1'b0;
      bus.rd             = '0;
      bus.readdata       = '0;
      bus.result_alu_out = '0;
      bus.rs1            = 5'd5;
      bus.rs2            = 5'd0;
      #2 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      checkEn = 1'b1;

      $display("[TB] reset state");
      @(negedge clk);
      checkOutput("rst_rdata1",  bus.rdata1, 64'h0);
      checkOutput("rst_rdata2",  bus.rdata2, 64'h0);
      checkOutput("rst_retire",  64'(bus.retire_count), 64'd0);
      checkOutput("rst_commit",  64'(bus.wb_commit), 64'd0);

      $display("[TB] bypass write to x5");
      applyStimulus(1, 0, 5'd5, 64'h0, 64'h0000_0000_DEAD_BEEF, 5'd5, 5'd0);
      @(negedge clk);
      checkOutput("bypass_rdata1", bus.rdata1, 64'h0000_0000_DEAD_BEEF);
      applyStimulus(0, 0, 5'd0, 64'h0, 64'h0, 5'd5, 5'd5);
      @(negedge clk);
      checkOutput("x5_commit", 64'(bus.wb_commit), 64'd1);
      checkOutput("x5_wb_rd",  64'(bus.wb_rd), 64'd5);
      checkOutput("x5_retire", 64'(bus.retire_count), 64'd1);
      checkOutput("x5_held",   bus.rdata2, 64'h0000_0000_DEAD_BEEF);

      $display("[TB] write to x0 discarded");
      applyStimulus(1, 1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 5'd0, 5'd0);
      @(negedge clk);
      checkOutput("x0_rdata1",  bus.rdata1, 64'h0);
      checkOutput("x0_wb_data", bus.wb_data, 64'hFFFF_FFFF_FFFF_FFFF);
      applyStimulus(0, 0, 5'd0, 64'h0, 64'h0, 5'd0, 5'd0);
      @(negedge clk);
      checkOutput("x0_commit", 64'(bus.wb_commit), 64'd0);
      checkOutput("x0_retire", 64'(bus.retire_count), 64'd1);
      checkOutput("x0_wb_rd",  64'(bus.wb_rd), 64'd5);

      $display("[TB] back-to-back writes to x7");
      applyStimulus(1, 0, 5'd7, 64'h0, 64'h11, 5'd0, 5'd7);
      @(negedge clk);
      checkOutput("x7_first",  bus.rdata2, 64'h11);
      applyStimulus(1, 0, 5'd7, 64'h0, 64'h22, 5'd0, 5'd7);
      @(negedge clk);
      checkOutput("x7_second", bus.rdata2, 64'h22);
      applyStimulus(0, 0, 5'd0, 64'h0, 64'h0, 5'd0, 5'd7);
      @(negedge clk);
      checkOutput("x7_after",  bus.rdata2, 64'h22);
      checkOutput("x7_retire", 64'(bus.retire_count), 64'd3);

      $display("[TB] retire counter wrap on the 4-bit instance");
      repeat (12) applyStimulus(1, 0, 5'd3, 64'h0, {$urandom, $urandom}, 5'd3, 5'd0);
      applyStimulus(0, 0, 5'd0, 64'h0, 64'h0, 5'd3, 5'd0);
      @(negedge clk);
      checkOutput("small_allones", 64'(bus_s.retire_count), 64'd15);
      applyStimulus(1, 0, 5'd3, 64'h0, 64'h33, 5'd3, 5'd0);
      applyStimulus(0, 0, 5'd0, 64'h0, 64'h0, 5'd3, 5'd0);
      @(negedge clk);
      checkOutput("small_wrap",   64'(bus_s.retire_count), 64'd0);
      checkOutput("big_no_wrap",  64'(bus.retire_count), 64'd16);
      checkOutput("x3_value",     bus.rdata1, 64'h33);

      $display("[TB] asynchronous reset mid-cycle");
      applyStimulus(1, 0, 5'd9, 64'h0, 64'hABCD, 5'd9, 5'd0);
      applyStimulus(0, 0, 5'd0, 64'h0, 64'h0, 5'd9, 5'd0);
      @(negedge clk);
      checkOutput("x9_written", bus.rdata1, 64'hABCD);
      applyStimulus(1, 0, 5'd9, 64'h0, 64'h5555, 5'd9, 5'd0);
      #2 reset = 1'b1;
      #1;
      checkOutput("async_rdata1", bus.rdata1, 64'h0);
      checkOutput("async_retire", 64'(bus.retire_count), 64'd0);
      checkOutput("async_commit", 64'(bus.wb_commit), 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      bus.Regwrite = 1'b0;
      @(negedge clk);
      checkOutput("x9_cleared", bus.rdata1, 64'h0);
      applyStimulus(1, 0, 5'd9, 64'h0, 64'h77, 5'd0, 5'd0);
      applyStimulus(0, 0, 5'd0, 64'h0, 64'h0, 5'd9, 5'd0);
      @(negedge clk);
      checkOutput("post_rst_write",  bus.rdata1, 64'h77);
      checkOutput("post_rst_retire", 64'(bus.retire_count), 64'd1);

      $display("[TB] randomized traffic");
      for (int n = 0; n < 600; n++) begin
         logic     rw;
         reg_idx_t rdIdx, r1, r2;
         rw    = ($urandom_range(0, 3) != 0);
         rdIdx = reg_idx_t'($urandom_range(0, 31));
         r1    = ($urandom_range(0, 2) == 0) ? rdIdx : reg_idx_t'($urandom_range(0, 31));
         r2    = ($urandom_range(0, 2) == 0) ? rdIdx : reg_idx_t'($urandom_range(0, 31));
         applyStimulus(rw, 1'($urandom_range(0, 1)), rdIdx,
                       {$urandom, $urandom}, {$urandom, $urandom}, r1, r2);
         if ($urandom_range(0, 79) == 0) begin
            #2 reset = 1'b1;
            @(posedge clk);
            #1 reset = 1'b0;
         end
      end

      applyStimulus(0, 0, 5'd0, 64'h0, 64'h0, 5'd0, 5'd0);
      @(negedge clk);
      checkEn = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Consumer end of the MEM/WB pipeline register: takes the registered writeback bundle and selects the writeback value (load data or ALU result).
- Commits the value into a 32 x 64-bit integer register file.
- Serves the two ID-stage read ports, with a same-cycle write-to-read bypass.
- Produces a registered commit pulse and a retire counter for debug and performance visibility.

Parameters:
- XLEN, 64, data width of registers and writeback paths
- NREG, 32, number of architectural registers; x0 is hardwired to zero
- AW, 5, register index width (log2 NREG)
- CNTW, 32, retire counter width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- readdata  in  XLEN  load data from MEM/WB
- result_alu_out  in  XLEN  ALU result from MEM/WB
- rd  in  AW  destination register from MEM/WB
- Memtoreg  in  1  1 selects readdata, 0 selects result_alu_out
- Regwrite  in  1  write enable from MEM/WB
- rs1  in  AW  read port 1 index (ID stage)
- rs2  in  AW  read port 2 index (ID stage)
- rdata1  out  XLEN  read port 1 data
- rdata2  out  XLEN  read port 2 data
- wb_data  out  XLEN  selected writeback value (combinational; also feeds the forwarding unit)
- wb_commit  out  1  registered pulse, high the cycle after an effective write
- wb_rd  out  AW  registered index of the last effective write
- retire_count  out  CNTW  number of effective writes since reset

Behaviour:
- Reset is asynchronous and active-high. It overrides every other input.
- Reset values:
  - all NREG registers = 0
  - wb_commit = 0
  - wb_rd = 0
  - retire_count = 0
- While reset is high:
  - no writes occur
  - rdata1 and rdata2 = 0, with the bypass disabled
  - wb_data still follows the mux
- Writeback select (combinational): wb_data = Memtoreg ? readdata : result_alu_out, full XLEN, no extension.
- Effective write: we_eff = Regwrite && (rd != 0) && !reset.
- On a rising edge with we_eff, reg[rd] <= wb_data.
- Write to x0 is discarded:
  - reg[0] stays 0
  - no commit pulse
  - no count
- Read ports are combinational. For each port p, with index rsp:
  - if rsp == 0: rdatap = 0
  - else if we_eff and rd == rsp: rdatap = wb_data (bypass; write-before-read in the same cycle)
  - else: rdatap = reg[rsp]
- Both ports may read the same index and may both hit the bypass in the same cycle.
- Commit tracking (registered, latency 1 cycle after the write edge):
  - wb_commit <= we_eff
  - wb_rd <= we_eff ? rd : wb_rd (holds its value when there is no write)
  - retire_count <= retire_count + we_eff, modulo 2^CNTW
  - at all-ones, the next effective write wraps retire_count to 0
- Back-to-back writes to the same rd: the last edge wins. A read in the cycle of the second write sees the second value through the bypass.
- Reset asserted mid-stream: all state clears immediately, without waiting for a clock edge. A write presented in the same cycle as reset is lost.
- Reset deasserting: the first edge after deassertion with we_eff writes normally.
- Regwrite = 0: Memtoreg, rd, readdata and result_alu_out are don't-care for state. wb_data still reflects the mux.

Decomposition:
- Shared package cpu_pkg:
  - XLEN
  - AW
  - NREG
  - REG_ZERO = 5'd0
  - typedef reg_idx_t = logic[AW-1:0]
  - typedef xword_t = logic[XLEN-1:0]
- One natural sub-module, wb_select: the Memtoreg mux plus the we_eff qualification.
- The register array, bypass logic and counters stay in wb_regfile.

Test Plan:
- Reset, then read rs1=5 and rs2=0 -> rdata1=0, rdata2=0, retire_count=0, wb_commit=0.
- Regwrite=1, Memtoreg=0, result_alu_out=64'h0000_0000_DEAD_BEEF, rd=5, rs1=5 in the same cycle:
  - rdata1=64'hDEAD_BEEF via the bypass
  - next cycle: wb_commit=1, wb_rd=5, retire_count=1
  - reg[5] holds the value thereafter
- Regwrite=1, Memtoreg=1, readdata=64'hFFFF_FFFF_FFFF_FFFF, result_alu_out=64'h1, rd=0:
  - rs1=0 reads 0
  - wb_commit stays 0
  - retire_count unchanged
  - wb_data=64'hFFFF_FFFF_FFFF_FFFF
- Write rd=7 with 64'h11, then rd=7 with 64'h22 on consecutive cycles, rs2=7:
  - rdata2=64'h11 in the first cycle
  - rdata2=64'h22 in the second cycle
  - rdata2=64'h22 afterwards
  - retire_count increments by 2
- Preload retire_count to all-ones via 2^32-1 writes (or a force), then one write to rd=3 -> retire_count=0.
- Write reg[9]=64'hABCD. Assert reset between clock edges while presenting a write to rd=9 -> immediately rdata1(rs1=9)=0 and retire_count=0. After deassertion, reg[9] reads 0.
